// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared widths, latency and FSM encoding for fft_mag_peak
// SQ_MAG_EN selects exact squared magnitude instead of alpha-max-beta-min.
package fft_pkg;

  localparam int DEF_DATA_W = 16;

`ifdef SQ_MAG_EN
  localparam int MAG_LAT = 4;
`else
  localparam int MAG_LAT = 3;
`endif

  function automatic int mag_width(input int dw);
`ifdef SQ_MAG_EN
    return 2 * dw + 1;
`else
    return dw + 1;
`endif
  endfunction

  localparam int MAG_W = mag_width(DEF_DATA_W);

  // RAM word packing: {re, im}
  function automatic int re_msb(input int dw);
    return 2 * dw - 1;
  endfunction

  function automatic int re_lsb(input int dw);
    return dw;
  endfunction

  function automatic int im_msb(input int dw);
    return dw - 1;
  endfunction

  localparam int IM_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/fft_mag_calc.sv
// rtl/fft_mag_calc.sv - registered magnitude pipeline, latency MAG_LAT-1 from RAM data
// SQ_MAG_EN: re*re + im*im over three stages; otherwise saturating abs then alpha-max-beta-min.
module fft_mag_calc
  import fft_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  localparam int MW = mag_width(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] i_re,
  input  logic [DATA_W-1:0] i_im,
  output logic [MW-1:0]     o_mag
);

`ifdef SQ_MAG_EN
  logic signed [2*DATA_W-1:0] r_re, r_im, r_sq_re, r_sq_im;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_re    <= '0;
      r_im    <= '0;
      r_sq_re <= '0;
      r_sq_im <= '0;
      o_mag   <= '0;
    end else begin
      r_re    <= $signed({{DATA_W{i_re[DATA_W-1]}}, i_re});
      r_im    <= $signed({{DATA_W{i_im[DATA_W-1]}}, i_im});
      r_sq_re <= r_re * r_re;
      r_sq_im <= r_im * r_im;
      // Each square is non-negative; the extra bit holds the (-2^(N-1))^2 * 2 case.
      o_mag   <= {1'b0, r_sq_re} + {1'b0, r_sq_im};
    end
  end
`else
  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  logic [DATA_W-1:0] w_abs_re, w_abs_im, r_abs_re, r_abs_im, w_max, w_min;

  // The most negative code has no positive twin, so clamp it to full scale.
  assign w_abs_re = (i_re == MOST_NEG) ? ~MOST_NEG : (i_re[DATA_W-1] ? -i_re : i_re);
  assign w_abs_im = (i_im == MOST_NEG) ? ~MOST_NEG : (i_im[DATA_W-1] ? -i_im : i_im);
  assign w_max    = (r_abs_re >= r_abs_im) ? r_abs_re : r_abs_im;
  assign w_min    = (r_abs_re >= r_abs_im) ? r_abs_im : r_abs_re;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_abs_re <= '0;
      r_abs_im <= '0;
      o_mag    <= '0;
    end else begin
      r_abs_re <= w_abs_re;
      r_abs_im <= w_abs_im;
      o_mag    <= {1'b0, w_max} + {1'b0, w_min >> 2} + {1'b0, w_min >> 3};
    end
  end
`endif

endmodule

// File: rtl/fft_mag_peak.sv
// rtl/fft_mag_peak.sv - scans the lower half of the FFT RAM, streams magnitudes, tracks the peak bin
// SQ_MAG_EN (in fft_pkg/fft_mag_calc) switches to squared magnitude with one extra pipeline stage.
module fft_mag_peak
  import fft_pkg::*;
#(
  parameter int N_POINTS = 1024,
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = DEF_DATA_W,
  localparam int MW      = mag_width(DATA_W)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic [ADDR_W-1:0]   ram_addr,
  input  logic [2*DATA_W-1:0] ram_dout,
  output logic                busy,
  output logic                mag_valid,
  output logic [ADDR_W-1:0]   mag_bin,
  output logic [MW-1:0]       mag_data,
  output logic                done,
  output logic [ADDR_W-1:0]   peak_bin,
  output logic [MW-1:0]       peak_mag
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_POINTS / 2 - 1);

  state_t             r_state, w_next;
  logic [MAG_LAT-1:0] r_vld;
  logic [ADDR_W-1:0]  r_bin [MAG_LAT];
  logic               w_accept;

  assign w_accept = (r_state == ST_IDLE) && start;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b1;
    done   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) w_next = ST_READ;
      end
      ST_READ:  if (ram_addr == LAST_ADDR) w_next = ST_DRAIN;
      // Leave once the final bin is on the output and nothing follows it.
      ST_DRAIN: if (r_vld[MAG_LAT-1] && !r_vld[MAG_LAT-2]) w_next = ST_DONE;
      ST_DONE: begin
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ram_addr <= '0;
    end else if (w_accept) begin
      ram_addr <= '0;
    end else if (r_state == ST_READ && ram_addr != LAST_ADDR) begin
      ram_addr <= ram_addr + 1'b1;
    end
  end

  // Valid/bin delay line matched to the RAM read plus magnitude pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
      for (int i = 0; i < MAG_LAT; i++) r_bin[i] <= '0;
    end else begin
      r_vld    <= {r_vld[MAG_LAT-2:0], r_state == ST_READ};
      r_bin[0] <= ram_addr;
      for (int i = 1; i < MAG_LAT; i++) r_bin[i] <= r_bin[i-1];
    end
  end

  assign mag_valid = r_vld[MAG_LAT-1];
  assign mag_bin   = r_bin[MAG_LAT-1];

  fft_mag_calc #(
    .DATA_W (DATA_W)
  ) u_calc (
    .clk   (clk),
    .rst   (rst),
    .i_re  (ram_dout[re_msb(DATA_W):re_lsb(DATA_W)]),
    .i_im  (ram_dout[im_msb(DATA_W):IM_LSB]),
    .o_mag (mag_data)
  );

  // Strict compare keeps the earliest bin on ties.
  always_ff @(posedge clk) begin
    if (rst || w_accept) begin
      peak_bin <= '0;
      peak_mag <= '0;
    end else if (mag_valid && mag_data > peak_mag) begin
      peak_bin <= mag_bin;
      peak_mag <= mag_data;
    end
  end

endmodule

// File: tb/tb_fft_mag_peak.sv
// tb/tb_fft_mag_peak.sv - scoreboard bench for fft_mag_peak (honours SQ_MAG_EN)
module tb_fft_mag_peak;

`ifdef SQ_MAG_EN
  localparam int MW = 33;
  localparam int LAT = 4;
  localparam logic [MW-1:0] TONE_MAG = 33'd400000000;
  localparam logic [MW-1:0] SAT_MAG  = 33'd1073741824;
`else
  localparam int MW = 17;
  localparam int LAT = 3;
  localparam logic [MW-1:0] TONE_MAG = 17'd20500;
  localparam logic [MW-1:0] SAT_MAG  = 17'd32767;
`endif
  localparam int HALF = 512;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [9:0]    ram_addr;
  logic [31:0]   ram_dout;
  logic          busy, mag_valid, done;
  logic [9:0]    mag_bin, peak_bin;
  logic [MW-1:0] mag_data, peak_mag;

  logic [31:0] mem [1024];
  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [9:0]    bin;
    logic [MW-1:0] mag;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  int            s_first, s_last, s_nv, s_done, s_ndone, s_fall;
  bit            s_tout;
  logic [9:0]    s_addr1, s_pkb;
  logic          s_busy1;
  logic [MW-1:0] s_pk1, s_pkm;

  fft_mag_peak dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .ram_addr  (ram_addr),
    .ram_dout  (ram_dout),
    .busy      (busy),
    .mag_valid (mag_valid),
    .mag_bin   (mag_bin),
    .mag_data  (mag_data),
    .done      (done),
    .peak_bin  (peak_bin),
    .peak_mag  (peak_mag)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ram_dout <= mem[ram_addr];

  function automatic logic [MW-1:0] exp_mag(input logic [31:0] w);
    int re, im;
`ifdef SQ_MAG_EN
    longint s;
    re = $signed(w[31:16]);
    im = $signed(w[15:0]);
    s = longint'(re) * re + longint'(im) * im;
    return MW'(s);
`else
    int a, b, mx, mn;
    re = $signed(w[31:16]);
    im = $signed(w[15:0]);
    a = (re < 0) ? -re : re;
    b = (im < 0) ? -im : im;
    if (a > 32767) a = 32767;
    if (b > 32767) b = 32767;
    mx = (a > b) ? a : b;
    mn = (a > b) ? b : a;
    return MW'(mx + mn / 4 + mn / 8);
`endif
  endfunction

  task automatic model_peak(output logic [9:0] b, output logic [MW-1:0] m);
    b = '0;
    m = '0;
    for (int i = 0; i < HALF; i++) begin
      if (exp_mag(mem[i]) > m) begin
        m = exp_mag(mem[i]);
        b = 10'(i);
      end
    end
  endtask

  task automatic push_scan();
    for (int i = 0; i < HALF; i++) sb.push_back('{bin: 10'(i), mag: exp_mag(mem[i])});
  endtask

  task automatic fill(input int mode);
    for (int i = 0; i < 1024; i++) begin
      if (mode == 0) mem[i] = '0;
      else if ((i % 61) == 7) mem[i] = {16'h8000, 16'(i)};
      else mem[i] = $urandom;
    end
  endtask

  // Output-side scoreboard: every mag_valid must match the next expected bin.
  always @(negedge clk) begin
    if (!rst && mag_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL mon_unexpected_valid bin=%0d mag=%0d", mag_bin, mag_data);
      end else begin
        mon_e = sb.pop_front();
        if (mag_bin !== mon_e.bin || mag_data !== mon_e.mag) begin
          errors++;
          $display("FAIL mon_mag got bin=%0d mag=%0d want bin=%0d mag=%0d",
                   mag_bin, mag_data, mon_e.bin, mon_e.mag);
        end
      end
    end
  end

  task automatic run_scan(input int inj_at, input bit start_in_done);
    push_scan();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    s_addr1 = ram_addr;
    s_busy1 = busy;
    s_pk1   = peak_mag;
    s_first = -1; s_last = -1; s_nv = 0; s_done = -1; s_ndone = 0; s_fall = -1;
    s_tout  = 1'b1;
    for (int cyc = 1; cyc < 1500; cyc++) begin
      if (cyc > 1) begin
        @(posedge clk); #1;
      end
      start = 1'b0;
      if (mag_valid) begin
        if (s_first < 0) s_first = cyc;
        s_last = cyc;
        s_nv++;
      end
      if (done) begin
        s_ndone++;
        s_done = cyc;
        s_pkb  = peak_bin;
        s_pkm  = peak_mag;
        if (start_in_done) start = 1'b1;
      end
      if (!busy) begin
        s_fall = cyc;
        s_tout = 1'b0;
        break;
      end
      if (inj_at >= 0 && ram_addr == 10'(inj_at) && !mag_valid) start = 1'b1;
      else if (inj_at >= 0 && ram_addr == 10'(inj_at) && cyc < 300) start = 1'b1;
    end
    start = 1'b0;
  endtask

  task automatic check_scan(input string nm);
    checks++;
    if (s_tout) begin errors++; $display("FAIL %s_timeout got busy stuck want busy fall", nm); end
    checks++;
    if (s_nv != HALF) begin errors++; $display("FAIL %s_nvalid got %0d want %0d", nm, s_nv, HALF); end
    checks++;
    if (s_ndone != 1) begin errors++; $display("FAIL %s_ndone got %0d want 1", nm, s_ndone); end
    checks++;
    if (s_done != s_last + 1) begin
      errors++; $display("FAIL %s_done_pos got %0d want %0d", nm, s_done, s_last + 1);
    end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL %s_sb_left got %0d want 0", nm, sb.size()); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, mag_valid, done} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got %b want 000", {busy, mag_valid, done});
    end
    checks++;
    if (ram_addr !== 10'd0 || mag_bin !== 10'd0 || mag_data !== '0) begin
      errors++; $display("FAIL reset_data got addr=%0d bin=%0d mag=%0d want 0", ram_addr, mag_bin, mag_data);
    end
    checks++;
    if (peak_bin !== 10'd0 || peak_mag !== '0) begin
      errors++; $display("FAIL reset_peak got bin=%0d mag=%0d want 0", peak_bin, peak_mag);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_tone();
    fill(0);
    mem[37] = {16'(16000), 16'(-12000)};
    run_scan(-1, 1'b0);
    check_scan("tone");
    checks++;
    if (s_addr1 !== 10'd0 || s_busy1 !== 1'b1) begin
      errors++; $display("FAIL lat_start got addr=%0d busy=%b want addr=0 busy=1", s_addr1, s_busy1);
    end
    checks++;
    if (s_first != LAT + 1) begin
      errors++; $display("FAIL lat_first_valid got %0d want %0d", s_first, LAT + 1);
    end
    checks++;
    if (s_fall != s_done + 1) begin
      errors++; $display("FAIL lat_busy_fall got %0d want %0d", s_fall, s_done + 1);
    end
    checks++;
    if (s_pkb !== 10'd37 || s_pkm !== TONE_MAG) begin
      errors++; $display("FAIL tone_peak got bin=%0d mag=%0d want bin=37 mag=%0d", s_pkb, s_pkm, TONE_MAG);
    end
  endtask

  task automatic test_sat_tie();
    fill(0);
    mem[5] = {16'h8000, 16'h0000};
    mem[9] = {16'h8000, 16'h0000};
    run_scan(-1, 1'b0);
    check_scan("sat");
    checks++;
    if (s_pkb !== 10'd5 || s_pkm !== SAT_MAG) begin
      errors++; $display("FAIL sat_tie_peak got bin=%0d mag=%0d want bin=5 mag=%0d", s_pkb, s_pkm, SAT_MAG);
    end
  endtask

  task automatic test_start_while_busy();
    logic [9:0]    eb;
    logic [MW-1:0] em;
    fill(1);
    model_peak(eb, em);
    run_scan(200, 1'b0);
    check_scan("busy_start");
    checks++;
    if (s_pkb !== eb || s_pkm !== em) begin
      errors++; $display("FAIL busy_start_peak got bin=%0d mag=%0d want bin=%0d mag=%0d", s_pkb, s_pkm, eb, em);
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0]    eb;
    logic [MW-1:0] em;
    int            stray;
    fill(1);
    model_peak(eb, em);
    run_scan(-1, 1'b1);
    check_scan("b2b");
    checks++;
    if (s_pk1 !== '0) begin errors++; $display("FAIL b2b_peak_clear got %0d want 0", s_pk1); end
    checks++;
    if (s_pkb !== eb || s_pkm !== em) begin
      errors++; $display("FAIL b2b_peak got bin=%0d mag=%0d want bin=%0d mag=%0d", s_pkb, s_pkm, eb, em);
    end
    stray = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (busy !== 1'b0 || mag_valid !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin errors++; $display("FAIL done_start_ignored got %0d busy cycles want 0", stray); end
    checks++;
    if (ram_addr !== 10'd511) begin errors++; $display("FAIL addr_hold got %0d want 511", ram_addr); end
  endtask

  task automatic test_reset_mid_scan();
    int found, bad;
    fill(1);
    push_scan();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    found = 0;
    for (int i = 0; i < 300; i++) begin
      if (ram_addr == 10'd100) begin
        found = 1;
        break;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (found == 0) begin errors++; $display("FAIL rst_mid_reach got addr=%0d want 100", ram_addr); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || mag_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid_flush got busy=%b valid=%b want 0 0", busy, mag_valid);
    end
    rst = 1'b0;
    sb.delete();
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || mag_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rst_mid_quiet got %0d active cycles want 0", bad); end
    run_scan(-1, 1'b0);
    check_scan("rst_mid_rescan");
  endtask

  task automatic test_all_zero();
    fill(0);
    run_scan(-1, 1'b0);
    check_scan("zero");
    checks++;
    if (s_pkb !== 10'd0 || s_pkm !== '0) begin
      errors++; $display("FAIL zero_peak got bin=%0d mag=%0d want 0 0", s_pkb, s_pkm);
    end
  endtask

`ifdef SQ_MAG_EN
  task automatic test_sq();
    fill(0);
    mem[3] = {16'd3, 16'd4};
    run_scan(-1, 1'b0);
    check_scan("sq_small");
    checks++;
    if (s_pkb !== 10'd3 || s_pkm !== 33'd25) begin
      errors++; $display("FAIL sq_small_peak got bin=%0d mag=%0d want bin=3 mag=25", s_pkb, s_pkm);
    end
    mem[3] = {16'h8000, 16'h8000};
    run_scan(-1, 1'b0);
    check_scan("sq_big");
    checks++;
    if (s_pkm !== 33'h0_8000_0000) begin
      errors++; $display("FAIL sq_big_peak got %0d want 2147483648", s_pkm);
    end
  endtask
`endif

  initial begin
    fill(0);
    test_reset();
    test_single_tone();
    test_sat_tie();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_scan();
    test_all_zero();
`ifdef SQ_MAG_EN
    test_sq();
`endif
    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
